cache_switch_controller: RTL and testbench

Sequences an OS-initiated cache switch for the RISC-V pipeline. The switch request comes from the switch_cache_w decode path, qualified in EX, with the target cache index taken from rs1 data. The block freezes the pipeline, drains in-flight data-memory traffic, optionally flushes the outgoing cache bank, then retargets the active bank and releases the pipeline. It sits beside the flush/hazard logic, and its hold output is ORed into the IF/ID hold path.

---
 rtl/cache_switch_controller.sv | 107 ++++++++++
 tb/tb_cache_switch_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cache_switch_controller.sv
// OS-initiated cache bank switch sequencer: freezes the pipeline, drains data-memory
// traffic, optionally flushes the outgoing bank, retargets the active bank, then releases.
module cache_switch_controller #(
    parameter int NUM_CACHES      = 2,
    parameter int ID_W            = 1,
    parameter int CNT_W           = 16,
    parameter int FLUSH_ON_SWITCH = 1,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             switch_req,
    input  logic [ID_W-1:0]  switch_target,
    input  logic             d_mem_busy,
    input  logic             flush_done,
    output logic             flush_req,
    output logic [ID_W-1:0]  flush_bank,
    output logic             hold_pipeline,
    output logic [ID_W-1:0]  active_cache,
    output logic             switch_done,
    output logic             bad_target,
    output logic [CNT_W-1:0] switch_count
);

    typedef enum logic [2:0] {IDLE, DRAIN, FLUSH, SWAP, SETTLE, DONE} state_t;

    state_t          state;
    logic [ID_W-1:0] target_q;
    logic [3:0]      settle_cnt;

    // The outgoing bank is always the one still active while flushing.
    assign flush_bank = active_cache;

    // Outputs are set on the transitions into/out of states so they stay registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            target_q      <= '0;
            settle_cnt    <= '0;
            active_cache  <= '0;
            switch_count  <= '0;
            flush_req     <= 1'b0;
            hold_pipeline <= 1'b0;
            switch_done   <= 1'b0;
            bad_target    <= 1'b0;
        end else begin
            switch_done <= 1'b0;
            bad_target  <= 1'b0;
            case (state)
                IDLE: begin
                    if (switch_req) begin
                        if (32'(switch_target) >= $unsigned(NUM_CACHES)) begin
                            bad_target <= 1'b1;
                        end else if (switch_target == active_cache) begin
                            switch_done <= 1'b1;
                        end else begin
                            target_q      <= switch_target;
                            hold_pipeline <= 1'b1;
                            state         <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!d_mem_busy) begin
                        if (FLUSH_ON_SWITCH != 0) begin
                            flush_req <= 1'b1;
                            state     <= FLUSH;
                        end else begin
                            state <= SWAP;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_done) begin
                        flush_req <= 1'b0;
                        state     <= SWAP;
                    end
                end
                SWAP: begin
                    active_cache <= target_q;
                    settle_cnt   <= 4'(SETTLE_CYCLES);
                    if (SETTLE_CYCLES == 0) begin
                        hold_pipeline <= 1'b0;
                        switch_done   <= 1'b1;
                        state         <= DONE;
                    end else begin
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt <= 4'd1) begin
                        hold_pipeline <= 1'b0;
                        switch_done   <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    switch_count <= switch_count + 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_switch_controller.sv
// Directed bench: main instance with flush and 2 settle cycles, plus a no-flush,
// no-settle instance with a 2-bit counter for back-to-back switches.
module tb_cache_switch_controller;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // instance A: NUM_CACHES=2, ID_W=2 so that target 3 is representable
    logic        a_req = 1'b0, a_busy = 1'b0, a_fdone = 1'b0;
    logic [1:0]  a_tgt = '0;
    logic        a_freq, a_hold, a_done, a_bad;
    logic [1:0]  a_fbank, a_active;
    logic [15:0] a_cnt;

    cache_switch_controller #(.NUM_CACHES(2), .ID_W(2), .CNT_W(16),
                              .FLUSH_ON_SWITCH(1), .SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .switch_req(a_req), .switch_target(a_tgt),
        .d_mem_busy(a_busy), .flush_done(a_fdone), .flush_req(a_freq),
        .flush_bank(a_fbank), .hold_pipeline(a_hold), .active_cache(a_active),
        .switch_done(a_done), .bad_target(a_bad), .switch_count(a_cnt));

    logic        b_req = 1'b0, b_busy = 1'b0, b_fdone = 1'b0;
    logic [0:0]  b_tgt = '0;
    logic        b_freq, b_hold, b_done, b_bad;
    logic [0:0]  b_fbank, b_active;
    logic [1:0]  b_cnt;

    cache_switch_controller #(.NUM_CACHES(2), .ID_W(1), .CNT_W(2),
                              .FLUSH_ON_SWITCH(0), .SETTLE_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .switch_req(b_req), .switch_target(b_tgt),
        .d_mem_busy(b_busy), .flush_done(b_fdone), .flush_req(b_freq),
        .flush_bank(b_fbank), .hold_pipeline(b_hold), .active_cache(b_active),
        .switch_done(b_done), .bad_target(b_bad), .switch_count(b_cnt));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are checked 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // reset state
        #12;
        chk("rst_hold", a_hold, 0);
        chk("rst_freq", a_freq, 0);
        chk("rst_active", a_active, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_done", a_done, 0);
        chk("rst_bad", a_bad, 0);
        tick();
        reset = 1'b1;
        tick();

        // 1: nominal switch 0 -> 1
        a_req = 1'b1; a_tgt = 2'd1;
        tick();                                   // cycle 1, DRAIN
        a_req = 1'b0;
        chk("t1_c1_hold", a_hold, 1);
        chk("t1_c1_freq", a_freq, 0);
        tick();                                   // cycle 2, FLUSH
        chk("t1_c2_freq", a_freq, 1);
        chk("t1_c2_fbank", a_fbank, 0);
        chk("t1_c2_hold", a_hold, 1);
        a_fdone = 1'b0;
        tick();                                   // cycle 3, FLUSH, ack this cycle
        a_fdone = 1'b1;
        chk("t1_c3_freq", a_freq, 1);
        tick();                                   // cycle 4, SWAP
        a_fdone = 1'b0;
        chk("t1_c4_freq", a_freq, 0);
        chk("t1_c4_hold", a_hold, 1);
        chk("t1_c4_active", a_active, 0);
        tick();                                   // cycle 5, SETTLE
        chk("t1_c5_active", a_active, 1);
        chk("t1_c5_hold", a_hold, 1);
        tick();                                   // cycle 6, SETTLE
        chk("t1_c6_hold", a_hold, 1);
        chk("t1_c6_done", a_done, 0);
        tick();                                   // cycle 7, DONE
        chk("t1_c7_hold", a_hold, 0);
        chk("t1_c7_done", a_done, 1);
        tick();
        chk("t1_c8_done", a_done, 0);
        chk("t1_cnt", a_cnt, 1);

        // 2: busy held for 5 cycles in DRAIN, switch 1 -> 0
        a_req = 1'b1; a_tgt = 2'd0; a_busy = 1'b1;
        tick();
        a_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk("t2_drain_hold", a_hold, 1);
            chk("t2_drain_freq", a_freq, 0);
            tick();
        end
        a_busy = 1'b0;                            // cycle 6, still DRAIN
        chk("t2_c6_freq", a_freq, 0);
        tick();                                   // cycle 7, FLUSH
        chk("t2_c7_freq", a_freq, 1);
        chk("t2_c7_fbank", a_fbank, 1);
        a_fdone = 1'b1;
        tick();                                   // SWAP
        a_fdone = 1'b0;
        chk("t2_swap_freq", a_freq, 0);
        tick(); tick(); tick();                   // SETTLE, SETTLE, DONE
        chk("t2_done", a_done, 1);
        tick();
        chk("t2_active", a_active, 0);
        chk("t2_cnt", a_cnt, 2);

        // 3: no-op target then out-of-range target
        a_req = 1'b1; a_tgt = 2'd0;
        tick();
        a_req = 1'b0;
        chk("t3_noop_done", a_done, 1);
        chk("t3_noop_hold", a_hold, 0);
        tick();
        chk("t3_noop_done_clr", a_done, 0);
        chk("t3_noop_hold2", a_hold, 0);
        a_req = 1'b1; a_tgt = 2'd3;
        tick();
        a_req = 1'b0;
        chk("t3_bad", a_bad, 1);
        chk("t3_bad_hold", a_hold, 0);
        chk("t3_bad_done", a_done, 0);
        tick();
        chk("t3_bad_clr", a_bad, 0);
        chk("t3_active", a_active, 0);
        chk("t3_cnt", a_cnt, 2);

        // 4: flush ack delayed 10 cycles, switch 0 -> 1
        a_req = 1'b1; a_tgt = 2'd1;
        tick();                                   // DRAIN
        a_req = 1'b0;
        tick();                                   // FLUSH entered
        for (int k = 0; k < 10; k++) begin
            chk("t4_wait_freq", a_freq, 1);
            chk("t4_wait_active", a_active, 0);
            tick();
        end
        a_fdone = 1'b1;
        chk("t4_ack_freq", a_freq, 1);
        tick();                                   // SWAP
        a_fdone = 1'b0;
        chk("t4_swap_freq", a_freq, 0);
        chk("t4_swap_hold", a_hold, 1);
        chk("t4_swap_active", a_active, 0);
        tick();
        chk("t4_active", a_active, 1);
        tick(); tick();                           // SETTLE, DONE
        chk("t4_done", a_done, 1);
        tick();
        chk("t4_cnt", a_cnt, 3);

        // 5: reset during SETTLE, switch 1 -> 0
        a_req = 1'b1; a_tgt = 2'd0;
        tick();                                   // DRAIN
        a_req = 1'b0;
        tick();                                   // FLUSH
        a_fdone = 1'b1;
        tick();                                   // SWAP
        a_fdone = 1'b0;
        tick();                                   // SETTLE
        chk("t5_settle_hold", a_hold, 1);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_hold", a_hold, 0);
        chk("t5_rst_freq", a_freq, 0);
        chk("t5_rst_done", a_done, 0);
        chk("t5_rst_active", a_active, 0);
        chk("t5_rst_cnt", a_cnt, 0);
        tick();
        reset = 1'b1;
        tick();
        a_req = 1'b1; a_tgt = 2'd1;
        tick();
        a_req = 1'b0;
        tick();                                   // FLUSH
        a_fdone = 1'b0;
        tick();
        a_fdone = 1'b1;
        tick();                                   // SWAP
        a_fdone = 1'b0;
        tick(); tick(); tick();                   // SETTLE, SETTLE, DONE
        chk("t5_after_done", a_done, 1);
        tick();
        chk("t5_after_active", a_active, 1);
        chk("t5_after_cnt", a_cnt, 1);

        // 6: no flush, no settle, 2-bit counter, five back-to-back switches
        chk("t6_init_cnt", b_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            b_req = 1'b1;
            b_tgt = (i % 2 == 0) ? 1'b1 : 1'b0;
            tick();                               // DRAIN
            b_req = 1'b0;
            chk("t6_drain_hold", b_hold, 1);
            chk("t6_drain_freq", b_freq, 0);
            tick();                               // SWAP
            chk("t6_swap_hold", b_hold, 1);
            chk("t6_swap_freq", b_freq, 0);
            tick();                               // DONE
            chk("t6_done", b_done, 1);
            chk("t6_done_hold", b_hold, 0);
            chk("t6_active", b_active, (i % 2 == 0) ? 1 : 0);
            tick();                               // IDLE, next request issued here
            chk("t6_cnt", b_cnt, exp_cnt[i]);
            chk("t6_done_clr", b_done, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
